wb_cmd_initiator: RTL
=====================

Name: wb_cmd_initiator

Overview:
Single-outstanding Wishbone classic initiator that turns a valid/ready command stream into one bus cycle per command and returns a response on a second valid/ready stream. It is the master-side counterpart of the peripheral register slaves (counter/timers, GPIO, etc.) on the management Wishbone bus. A bounded ack timeout means a missing or unmapped slave cannot hang the command source.

Parameters:
TIMEOUT, 255, number of cycles STB may stay asserted without ACK before the cycle is aborted. Legal range is 1..65535.
ERR_DATA, 32'hFFFF_FFFF, value returned on rsp_dat_o when a cycle times out.

Ports:
wb_clk_i  input  1  clock for all logic
wb_rst_i  input  1  synchronous, active-high reset
cmd_valid_i  input  1  command offered
cmd_ready_o  output  1  command accepted when valid&ready
cmd_we_i  input  1  1 = write, 0 = read
cmd_adr_i  input  32  byte address
cmd_dat_i  input  32  write data
cmd_sel_i  input  4  byte selects
rsp_valid_o  output  1  response available
rsp_ready_i  input  1  response consumed when valid&ready
rsp_dat_o  output  32  read data, 0 for writes, ERR_DATA on timeout
rsp_err_o  output  1  1 = timeout
busy_o  output  1  state != IDLE
wbm_cyc_o  output  1  Wishbone CYC
wbm_stb_o  output  1  Wishbone STB (always equal to CYC)
wbm_we_o  output  1  Wishbone WE
wbm_adr_o  output  32  Wishbone address
wbm_dat_o  output  32  Wishbone write data
wbm_sel_o  output  4  Wishbone byte selects
wbm_ack_i  input  1  slave ack; may be combinational from STB
wbm_dat_i  input  32  slave read data

Behaviour:
- Reset (synchronous, wb_rst_i=1 at a clock edge) forces:
  - state=IDLE
  - cyc/stb/we=0; adr/dat/sel=0
  - rsp_valid_o=0, rsp_err_o=0, rsp_dat_o=0
  - timeout counter=0
  - cmd_ready_o=1 from the first cycle after reset deasserts
- Reset mid-operation takes effect at the same edge whatever the state. A bus cycle in progress is abandoned and no response is produced.
- All outputs are registered or decoded from registered state only. cmd_ready_o = (state==IDLE). There are no combinational paths from inputs to outputs.
- States:
  - IDLE: on cmd_valid_i, latch we/adr/dat/sel into the wbm_* registers, set cyc=stb=1, clear the counter, go to BUS.
  - BUS: cyc/stb held; wbm_* outputs stay stable for the whole cycle.
    - ack=1: capture rsp_dat_o = we ? 0 : wbm_dat_i and rsp_err_o=0; drop cyc/stb at this edge; set rsp_valid_o=1; go to RESP.
    - ack=0 and counter==TIMEOUT-1: rsp_dat_o=ERR_DATA, rsp_err_o=1; drop cyc/stb; rsp_valid_o=1; go to RESP.
    - Otherwise: counter++.
    - STB is therefore high for at most TIMEOUT cycles.
  - RESP: hold rsp_* stable. On rsp_ready_i, clear rsp_valid_o and go to IDLE. A new command can be accepted in the cycle after the handshake.
- Simultaneous ack and timeout in the same cycle: ack wins, err=0.
- wbm_ack_i outside BUS is ignored and must not change any state.
- Latency with a combinational-ack slave: command handshake at cycle 0, STB high in cycle 1 only, rsp_valid_o high from cycle 2. A slave that acks after N wait cycles gives rsp_valid_o at cycle 2+N.
- Throughput is at most one command per 3 cycles. Only one command is ever outstanding.
- The counter is 16 bits wide and never wraps, because the TIMEOUT bound is hit first.

Test Plan:
1. Combinational-ack slave, write adr=32'h2400_0000, dat=32'h0000_0011, sel=4'hF → wbm_* match the command and STB is high for exactly 1 cycle; rsp_valid at cycle 2 with rsp_dat=0, err=0.
2. Read adr=32'h2400_0008 from a slave that acks 3 cycles after STB with dat=32'h1234_5678 → STB high for 4 cycles; rsp_dat=32'h1234_5678, err=0; cmd_ready low throughout.
3. No-ack slave, TIMEOUT=255 → STB high for exactly 255 cycles, then drops; rsp_dat=32'hFFFF_FFFF, err=1; the next command completes normally.
4. Hold rsp_ready=0 for 10 cycles after rsp_valid → rsp_* stable, cmd_ready=0, no bus activity; after the handshake, cmd_ready=1 on the next cycle.
5. Reset asserted on the 2nd cycle of a wait-stated BUS → cyc/stb=0 and rsp_valid=0 at the next edge; no response is ever issued; cmd_ready=1 after reset deasserts.
6. TIMEOUT=4, slave acks on the 4th STB cycle (data 32'hA5A5_A5A5) → err=0, rsp_dat=32'hA5A5_A5A5. Also drive a stray ack in IDLE and in RESP → no state change.

Source files
------------

// File: rtl/wb_cmd_initiator.sv
// Single-outstanding Wishbone classic initiator: one bus cycle per command
// on a valid/ready stream, response returned on a second valid/ready stream.
module wb_cmd_initiator #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        busy_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } req_t;

  typedef struct packed {
    logic        err;
    logic [31:0] dat;
  } rsp_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_nx;
  req_t        req_q, req_nx;
  rsp_t        rsp_q, rsp_nx;
  logic        cyc_q, cyc_nx;
  logic        rvld_q, rvld_nx;
  logic [15:0] cnt_q, cnt_nx;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      req_q   <= '0;
      rsp_q   <= '0;
      cyc_q   <= 1'b0;
      rvld_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nx;
      req_q   <= req_nx;
      rsp_q   <= rsp_nx;
      cyc_q   <= cyc_nx;
      rvld_q  <= rvld_nx;
      cnt_q   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    req_nx   = req_q;
    rsp_nx   = rsp_q;
    cyc_nx   = cyc_q;
    rvld_nx  = rvld_q;
    cnt_nx   = cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          req_nx   = '{we: cmd_we_i, adr: cmd_adr_i, dat: cmd_dat_i, sel: cmd_sel_i};
          cyc_nx   = 1'b1;
          cnt_nx   = '0;
          state_nx = BUS;
        end
      end
      BUS: begin
        // ack beats a coincident timeout
        if (wbm_ack_i) begin
          rsp_nx.err = 1'b0;
          rsp_nx.dat = req_q.we ? 32'h0 : wbm_dat_i;
          cyc_nx     = 1'b0;
          rvld_nx    = 1'b1;
          state_nx   = RESP;
        end else if (cnt_q == TO_LAST) begin
          rsp_nx.err = 1'b1;
          rsp_nx.dat = ERR_DATA;
          cyc_nx     = 1'b0;
          rvld_nx    = 1'b1;
          state_nx   = RESP;
        end else begin
          cnt_nx = cnt_q + 16'd1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rvld_nx  = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign rsp_valid_o = rvld_q;
  assign rsp_dat_o   = rsp_q.dat;
  assign rsp_err_o   = rsp_q.err;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = req_q.we;
  assign wbm_adr_o   = req_q.adr;
  assign wbm_dat_o   = req_q.dat;
  assign wbm_sel_o   = req_q.sel;

endmodule
